sub_serial4: RTL and testbench
==============================

Name: sub_serial4

Overview:
- Multi-cycle, digit-serial subtractor. Computes d = a - b - bin on N-bit operands, 4 bits per clock, LSB digit first, with a registered borrow between digits.
- Complements the team's combinational 4-bit-block carry-lookahead adder. It is the area-lean subtract path for datapaths that can tolerate N/4+ cycles of latency.
- Uses a valid/ready handshake on both the operand side and the result side.

Parameters:
- N, 32, operand/result width. Must be a multiple of 4 and at least 4. Digit count is N/4.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  N  minuend, unsigned or two's-complement.
- b  input  N  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result d, bout, ovf, zero are valid.
- out_ready  input  1  consumer accepts the result.
- d  output  N  difference, a - b - bin mod 2^N.
- bout  output  1  unsigned borrow out. 1 iff a < b + bin.
- ovf  output  1  signed overflow.
- zero  output  1  1 iff d == 0.

Behaviour:
- Reset (rst_n low, takes effect immediately, any state):
  - state = IDLE, digit counter = 0, internal borrow = 0.
  - d = 0, bout = 0, ovf = 0, zero = 0, out_valid = 0.
  - Any in-flight operation is discarded.
- in_ready = (state == IDLE), combinational from state. It reads 1 while in reset.
- out_valid = (state == DONE).
- FSM, IDLE:
  - On a rising edge with in_valid && in_ready, latch a, b into working registers and bin into the borrow register.
  - Clear the digit counter and go to RUN.
- FSM, RUN:
  - Each cycle, take digit k (bits 4k+3..4k) and compute {borrow', digit} = a_k - b_k - borrow.
  - Store the digit into the result working register and update the borrow.
  - Increment k.
  - After processing digit N/4-1, go to DONE. On the same edge, copy the result to d, set bout = final borrow, compute ovf and zero.
- FSM, DONE:
  - Hold all outputs stable.
  - On a rising edge with out_ready = 1, go to IDLE.
  - out_ready while not in DONE is ignored.
- Latency:
  - Acceptance edge E0. Digit k is computed on edge E(k+1).
  - out_valid is high starting after edge E(N/4), i.e. 8 edges after acceptance for N = 32.
  - IDLE is re-entered on the edge after out_ready is sampled high. No same-cycle accept on result hand-off.
  - Throughput: one operation per N/4 + 2 cycles with out_ready held high.
- Output stability: d, bout, ovf, zero change only on the transition into DONE, or on reset. Between operations they hold the last result.
- Operand isolation: changes on a, b, bin or in_valid while state != IDLE are ignored. Nothing is queued.
- ovf:
  - 1 iff the exact integer a_s - b_s - bin lies outside [-2^(N-1), 2^(N-1)-1], where a_s and b_s are the two's-complement values.
  - Equivalently, the borrow into the MSB XOR the borrow out of the MSB.
- Arithmetic is exact modulo 2^N. No saturation.

Test Plan:
1. N = 32, a = 0x00000005, b = 0x00000003, bin = 0 -> d = 0x00000002, bout = 0, ovf = 0, zero = 0. out_valid rises exactly 8 edges after acceptance.
2. a = 0x00000000, b = 0x00000001, bin = 0 -> d = 0xFFFFFFFF, bout = 1, ovf = 0, zero = 0.
3. a = 0x80000000, b = 0x00000001, bin = 0 -> d = 0x7FFFFFFF, bout = 0, ovf = 1. Also a = 0x10000000, b = 0x00000001 -> d = 0x0FFFFFFF, exercising a borrow ripple across 7 digits.
4. a = 0x12345678, b = 0x12345677, bin = 1 -> d = 0x00000000, zero = 1, bout = 0, ovf = 0.
5. Backpressure: hold out_ready = 0 for 10 cycles in DONE -> out_valid = 1 and d/bout/ovf/zero stable, in_ready = 0, and a pulsed in_valid with new operands is ignored. Then out_ready = 1 for one edge -> out_valid = 0 and in_ready = 1 on the next cycle, and the next operation gives the correct result.
6. Assert rst_n low mid-RUN (after digit 3) -> out_valid = 0, d = 0, bout = 0 immediately without waiting for a clock edge. After release, in_ready = 1, and a fresh a = 0x00000100, b = 0x00000001 -> d = 0x000000FF.

Source files
------------

// File: rtl/sub_serial4.sv
// Digit-serial subtractor: d = a - b - bin, one 4-bit digit per clock, LSB digit first.
// Operands are shifted down so the current digit always sits in the low nibble.
module sub_serial4 #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         ovf,
    output logic         zero
);

    localparam int DIGITS = N / 4;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [N-1:0]   res_reg;
    logic           borrow_reg;
    logic [CW-1:0]  cnt_reg;

    logic [4:0]     diff5;
    logic [N+3:0]   res_wide;
    logic [N-1:0]   res_shift;
    logic           last_digit;
    logic           ovf_calc;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);

    // Digit datapath; on the last digit the low nibble of a_reg/b_reg holds the original MSBs.
    always_comb begin
        diff5      = {1'b0, a_reg[3:0]} - {1'b0, b_reg[3:0]} - {4'b0000, borrow_reg};
        res_wide   = {diff5[3:0], res_reg};
        res_shift  = res_wide[N+3:4];
        last_digit = (cnt_reg == CW'(DIGITS - 1));
        ovf_calc   = (a_reg[3] ^ b_reg[3]) & (diff5[3] ^ a_reg[3]);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_digit) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            d          <= '0;
            bout       <= 1'b0;
            ovf        <= 1'b0;
            zero       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        borrow_reg <= bin;
                        cnt_reg    <= '0;
                    end
                end
                RUN: begin
                    a_reg      <= a_reg >> 4;
                    b_reg      <= b_reg >> 4;
                    res_reg    <= res_shift;
                    borrow_reg <= diff5[4];
                    cnt_reg    <= cnt_reg + CW'(1);
                    // Published outputs only move on the transition into DONE.
                    if (last_digit) begin
                        d    <= res_shift;
                        bout <= diff5[4];
                        ovf  <= ovf_calc;
                        zero <= (res_shift == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial4.sv
// Randomized self-checking bench for sub_serial4 (N = 32) against an arithmetic reference model.
module tb_sub_serial4;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] d;
    logic         bout;
    logic         ovf;
    logic         zero;

    int           n_checks;
    int           n_fail;
    logic [N-1:0] prev_d;
    logic         prev_bout;

    sub_serial4 #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic on the operands.
    task automatic model(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbin,
                         output logic [N-1:0] ed, output logic eb, output logic eo, output logic ez);
        logic [N:0] full;
        longint     s;
        full = {1'b0, ta} - {1'b0, tb} - {{N{1'b0}}, tbin};
        ed   = full[N-1:0];
        eb   = ({1'b0, ta} < ({1'b0, tb} + {{N{1'b0}}, tbin}));
        s    = longint'($signed(ta)) - longint'($signed(tb)) - longint'(tbin);
        eo   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        ez   = (ed == '0);
    endtask

    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbin,
                          input int hold);
        logic [N-1:0] ed;
        logic         eb, eo, ez;
        int           edges;
        model(ta, tb, tbin, ed, eb, eo, ez);
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; bin = 1'($urandom);
        edges = 0;
        while (!out_valid && edges < 20) begin
            check("d_hold_run", 64'(d), 64'(prev_d));
            @(posedge clk); #1;
            edges++;
        end
        check("latency", 64'(edges), 64'd8);
        check("d", 64'(d), 64'(ed));
        check("bout", 64'(bout), 64'(eb));
        check("ovf", 64'(ovf), 64'(eo));
        check("zero", 64'(zero), 64'(ez));
        $display("op a=%08h b=%08h bin=%0d -> d=%08h bout=%0d ovf=%0d zero=%0d latency=%0d",
                 ta, tb, tbin, d, bout, ovf, zero, edges);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("in_ready_done", 64'(in_ready), 64'd0);
            a = $urandom; b = $urandom; in_valid = 1'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("valid_hold", 64'(out_valid), 64'd1);
            check("d_hold", 64'(d), 64'(ed));
            check("flags_hold", 64'({bout, ovf, zero}), 64'({eb, eo, ez}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", 64'(out_valid), 64'd0);
        check("in_ready_back", 64'(in_ready), 64'd1);
        prev_d    = ed;
        prev_bout = eb;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
        prev_d = '0; prev_bout = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({d, bout, ovf, zero}), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0);
        run_op(32'h1000_0000, 32'h0000_0001, 1'b0, 0);
        run_op(32'h1234_5678, 32'h1234_5677, 1'b1, 0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 10);   // backpressure, ovf
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 0);

        // Reset mid-RUN after digit 3
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h0123_4567; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_d", 64'(d), 64'd0);
        check("rst_mid_bout", 64'(bout), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        $display("reset asserted mid-run: out_valid=%0d d=%08h bout=%0d", out_valid, d, bout);
        @(negedge clk);
        rst_n = 1'b1;
        prev_d = '0;
        run_op(32'h0000_0100, 32'h0000_0001, 1'b0, 0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] ra, rb;
            ra = $urandom; rb = $urandom;
            if (i % 8 == 0) rb = ra;
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
